aresetn_sequencer: RTL
======================

// Module: aresetn_sequencer
// PURPOSE
//  Consumes the synchronised per-domain aresetn and drives NUM_STAGES staged active-low
//  resets (e.g. interconnect, DMA, user IP). Stages are released in order 0..N-1.
//  Each release waits for the previous stage's ready/calibrated flag (or a timeout)
//  plus a fixed gap. Also provides a software-triggered soft reset that re-runs the
//  whole sequence.
// PARAMETERS
//  NUM_STAGES     3     number of staged reset outputs (>=1)
//  HOLD_CYCLES    16    cycles all stages are held in reset after reset/soft reset (>=1)
//  STAGE_DELAY    8     gap cycles between stage k ready and stage k+1 release (>=0)
//  READY_TIMEOUT  1024  max wait cycles for stage_ready[k]; 0 = wait forever
// PORTS
//  aclk           in   1           single clock
//  aresetn        in   1           synchronous, active-low reset
//  soft_reset     in   1           high on an edge (re)starts the sequence
//  stage_ready    in   NUM_STAGES  per-stage ready/locked/calibrated flags
//  stage_aresetn  out  NUM_STAGES  staged active-low resets, registered
//  busy           out  1           high while any stage is held or sequencing
//  done           out  1           1-cycle pulse when the last stage is released and ready
//  timeout        out  NUM_STAGES  sticky per-stage timeout flags
// BEHAVIOUR
//  - Reset event (edge R): aresetn=0 sampled, or soft_reset=1 sampled. aresetn has priority.
//    Both have the same effect at edge R:
//    - stage_aresetn=0, busy=1, done=0, timeout=0, cnt=0, state=HOLD.
//    - These are also the power-up reset values of all outputs.
//  - HOLD:
//    - cnt increments each edge.
//    - At edge R+HOLD_CYCLES: stage_aresetn[0]<=1, k=0, cnt=0, state=WAIT_READY.
//  - WAIT_READY(k):
//    - stage_ready[k] is first sampled on the edge after release.
//    - Ready seen at edge T: if k<NUM_STAGES-1, go to DELAY. Else state=RUN, busy<=0,
//      done<=1 at edge T.
//    - If READY_TIMEOUT!=0 and ready is not seen by edge release+READY_TIMEOUT, then
//      timeout[k]<=1 and the sequence proceeds exactly as if ready had been seen at that edge.
//  - DELAY:
//    - At edge T+STAGE_DELAY: stage_aresetn[k+1]<=1, k++, state=WAIT_READY.
//    - STAGE_DELAY=0 releases the next stage at edge T itself.
//  - RUN:
//    - stage_aresetn all 1; done cleared on the following edge.
//    - Later stage_ready drops are ignored (no re-sequencing).
//  - stage_aresetn is monotonic within a sequence: once released, a bit stays 1 until the
//    next reset event. Bit k never rises before bit k-1.
//  - A reset event in any state (incl. mid WAIT_READY/DELAY) aborts immediately.
//    done does not pulse for the aborted sequence.
//  - timeout bits hold until the next reset event.
//  - cnt width = $clog2(max(HOLD_CYCLES,STAGE_DELAY,READY_TIMEOUT)+1). Counters never wrap.
//  - No combinational path from inputs to outputs.
// TESTING (NUM_STAGES=3, HOLD=16, DELAY=8, TIMEOUT=64; L = last edge sampling aresetn=0)
//  1. stage_ready=3'b111 -> stage_aresetn 001@L+16, 011@L+25, 111@L+34;
//     done=1 only @L+35; busy=0 from L+35.
//  2. stage_ready[1]=0 -> 011@L+25, timeout=3'b010@L+89, 111@L+97, done@L+98.
//  3. In RUN, soft_reset pulse @S -> stage_aresetn=0, busy=1, timeout=0 @S;
//     001@S+16, 011@S+25, 111@S+34.
//  4. soft_reset asserted during stage-1 WAIT_READY -> immediate abort; full sequence
//     restarts from HOLD; no done pulse before the restarted sequence completes.
//  5. aresetn low for 1 cycle mid-DELAY -> all outputs at reset values next edge;
//     sequence repeats with the case-1 timing.
//  6. In RUN, drop stage_ready to 0 -> stage_aresetn stays 111, busy=0, no done pulse.

Source files
------------

// File: rtl/aresetn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : aresetn_sequencer
//  Description : Staged active-low reset release. All NUM_STAGES outputs are
//                held low for HOLD_CYCLES after a reset event (aresetn low or
//                soft_reset high). Stages are then released in order 0..N-1.
//                Each release waits for the previous stage's ready flag (or a
//                timeout) plus a fixed STAGE_DELAY gap.
//  Ports       : aclk          - single clock
//                aresetn       - synchronous active-low reset
//                soft_reset    - synchronous, high re-runs the whole sequence
//                stage_ready   - per-stage ready/locked/calibrated flags
//                stage_aresetn - staged active-low resets (registered)
//                busy          - high while any stage is held or sequencing
//                done          - 1-cycle pulse once the last stage is ready
//                timeout       - sticky per-stage ready-timeout flags
//  Revision    : 1.0 - initial release
// ============================================================================
module aresetn_sequencer #(
    parameter int NUM_STAGES    = 3,
    parameter int HOLD_CYCLES   = 16,
    parameter int STAGE_DELAY   = 8,
    parameter int READY_TIMEOUT = 1024
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  soft_reset,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_aresetn,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_STAGES-1:0] timeout
);

    localparam int c_max_hd  = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
    localparam int c_cnt_max = (c_max_hd > READY_TIMEOUT) ? c_max_hd : READY_TIMEOUT;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int c_k_w     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    // Terminal counts: the counter is cleared on entry to a state, so the
    // event at entry+N happens when the counter reads N-1.
    localparam logic [c_cnt_w-1:0] c_hold_last    = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_delay_last   = c_cnt_w'((STAGE_DELAY > 0) ? STAGE_DELAY - 1 : 0);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'((READY_TIMEOUT > 0) ? READY_TIMEOUT - 1 : 0);
    localparam logic [c_k_w-1:0]   c_k_last       = c_k_w'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DELAY = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_k_w-1:0]      r_k;

    state_t                w_state_nxt;
    logic [c_cnt_w-1:0]    w_cnt_nxt;
    logic [c_k_w-1:0]      w_k_nxt;
    logic [c_k_w-1:0]      w_k_inc;
    logic [NUM_STAGES-1:0] w_stage_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic [NUM_STAGES-1:0] w_timeout_nxt;
    logic                  w_ready_k;
    logic                  w_advance;
    logic                  w_release_next;

    assign w_k_inc = r_k + c_k_w'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_k_nxt        = r_k;
        w_stage_nxt    = stage_aresetn;
        w_busy_nxt     = busy;
        w_done_nxt     = 1'b0;
        w_timeout_nxt  = timeout;
        w_ready_k      = 1'b0;
        w_advance      = 1'b0;
        w_release_next = 1'b0;

        for (int i = 0; i < NUM_STAGES; i++) begin
            if (c_k_w'(i) == r_k) begin
                w_ready_k = stage_ready[i];
            end
        end

        case (r_state)
            ST_HOLD: begin
                if (r_cnt == c_hold_last) begin
                    w_stage_nxt[0] = 1'b1;
                    w_k_nxt        = '0;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = ST_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end

            ST_WAIT: begin
                if (w_ready_k) begin
                    w_advance = 1'b1;
                end else if ((READY_TIMEOUT != 0) && (r_cnt == c_timeout_last)) begin
                    // A timeout is treated exactly like a late ready.
                    w_advance = 1'b1;
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        if (c_k_w'(i) == r_k) begin
                            w_timeout_nxt[i] = 1'b1;
                        end
                    end
                end else if (READY_TIMEOUT != 0) begin
                    // With no timeout the counter is left idle so it never wraps.
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end

                if (w_advance) begin
                    w_cnt_nxt = '0;
                    if (r_k == c_k_last) begin
                        w_state_nxt = ST_RUN;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else if (STAGE_DELAY == 0) begin
                        w_release_next = 1'b1;
                    end else begin
                        w_state_nxt = ST_DELAY;
                    end
                end
            end

            ST_DELAY: begin
                if (r_cnt == c_delay_last) begin
                    w_release_next = 1'b1;
                    w_cnt_nxt      = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end

            ST_RUN: begin
                // Terminal: ready drops are ignored until the next reset event.
            end

            default: begin
                w_state_nxt = ST_HOLD;
                w_cnt_nxt   = '0;
            end
        endcase

        if (w_release_next) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (c_k_w'(i) == w_k_inc) begin
                    w_stage_nxt[i] = 1'b1;
                end
            end
            w_k_nxt     = w_k_inc;
            w_state_nxt = ST_WAIT;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn || soft_reset) begin
            r_state       <= ST_HOLD;
            r_cnt         <= '0;
            r_k           <= '0;
            stage_aresetn <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            timeout       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_k           <= w_k_nxt;
            stage_aresetn <= w_stage_nxt;
            busy          <= w_busy_nxt;
            done          <= w_done_nxt;
            timeout       <= w_timeout_nxt;
        end
    end

endmodule
`default_nettype wire
